// File: rtl/pcie_tx_tlp_gen_pkg.sv
// -----------------------------------------------------------------------------
// pcie_tx_tlp_gen_pkg
// Shared constants for the PCIe TX TLP generator: arbiter type codes, AXI
// stream tdest codes, maximum payload length in DW, FSM state encoding and
// small helpers for MWr beat count and last-beat keep.
// -----------------------------------------------------------------------------
package pcie_tx_tlp_gen_pkg;

  // Arbiter request type codes (one-hot).
  localparam logic [2:0] C_TYPE_CPLD = 3'b001;
  localparam logic [2:0] C_TYPE_MRD  = 3'b010;
  localparam logic [2:0] C_TYPE_MWR  = 3'b100;

  // tdest routing: requester path vs completer path.
  localparam logic C_TDEST_REQ = 1'b0;
  localparam logic C_TDEST_CPL = 1'b1;

  // Largest legal payload in DW.
  localparam logic [10:0] C_MAX_DW_LEN = 11'd1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_state_e;

  // Number of 128-bit payload beats for a DW length (len <= 1024 -> <= 256).
  function automatic logic [8:0] mwr_beats(input logic [10:0] len_dw);
    return 9'((len_dw + 11'd3) >> 2);
  endfunction

  // Per-DW keep of the final payload beat, from the DW count modulo 4.
  function automatic logic [3:0] last_keep(input logic [1:0] len_lsb);
    logic [3:0] keep;
    case (len_lsb)
      2'b01:   keep = 4'b0001;
      2'b10:   keep = 4'b0011;
      2'b11:   keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/pcie_tx_tlp_gen.sv
// -----------------------------------------------------------------------------
// pcie_tx_tlp_gen
// Turns one arbiter grant (CplD / MRd / MWr) into a TLP on a 128-bit AXI
// stream: a header beat, then either the CplD second data DW or the MWr
// payload forwarded from tx_mwr_data. A single output register holds the
// beat on tx_axis_* and is stable while tvalid & !tready.
//
// Ports
//   pcie_user_clk / pcie_user_rst        clock, synchronous active-high reset
//   tx_arb_valid/_gnt/_type/_rdy         request handshake from the arbiter
//   tx_pcie_len, tx_pcie_head            DW length, complete 128-bit header
//   tx_cpld_udata                        second DW of a 2-DW completion
//   tx_mwr_data/_valid/_rdy              MWr payload stream (upstream)
//   tx_axis_t*                           TLP stream (tkeep per DW)
//   tx_done, tx_done_gnt                 1-cycle pulse + grant of finished TLP
//   tx_err_len                           sticky illegal-length flag
// C_PCIE_DATA_WIDTH: only 128 is supported.
// -----------------------------------------------------------------------------
module pcie_tx_tlp_gen
  import pcie_tx_tlp_gen_pkg::*;
#(
  parameter int C_PCIE_DATA_WIDTH = 128
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst,
  input  logic                         tx_arb_valid,
  input  logic [5:0]                   tx_arb_gnt,
  input  logic [2:0]                   tx_arb_type,
  input  logic [10:0]                  tx_pcie_len,
  input  logic [C_PCIE_DATA_WIDTH-1:0] tx_pcie_head,
  input  logic [31:0]                  tx_cpld_udata,
  output logic                         tx_arb_rdy,
  input  logic [C_PCIE_DATA_WIDTH-1:0] tx_mwr_data,
  input  logic                         tx_mwr_data_valid,
  output logic                         tx_mwr_data_rdy,
  output logic [C_PCIE_DATA_WIDTH-1:0] tx_axis_tdata,
  output logic [3:0]                   tx_axis_tkeep,
  output logic                         tx_axis_tlast,
  output logic                         tx_axis_tdest,
  output logic                         tx_axis_tvalid,
  input  logic                         tx_axis_tready,
  output logic                         tx_done,
  output logic [5:0]                   tx_done_gnt,
  output logic                         tx_err_len
);

  tx_state_e                    state_q, state_d;
  logic [5:0]                   gnt_q, gnt_d;
  logic [2:0]                   type_q, type_d;
  logic [10:0]                  len_q, len_d;
  logic [31:0]                  udata_q, udata_d;
  logic [8:0]                   cnt_q, cnt_d;      // MWr payload beats still to take
  logic                         tvalid_q, tvalid_d;
  logic [C_PCIE_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [3:0]                   tkeep_q, tkeep_d;
  logic                         tlast_q, tlast_d;
  logic                         tdest_q, tdest_d;
  logic                         done_q, done_d;
  logic [5:0]                   done_gnt_q, done_gnt_d;
  logic                         err_q, err_d;

  logic beat_xfer;
  logic mwr_take;
  logic known_type;
  logic is_cpld;
  logic len_bad;
  logic [10:0] eff_len;

  // Combinational handshakes are gated by reset so nothing is offered or
  // consumed while the block is being reset.
  assign tx_arb_rdy      = !pcie_user_rst && (state_q == ST_IDLE);
  // A payload beat may enter the output register when it is empty or draining.
  assign tx_mwr_data_rdy = !pcie_user_rst && (state_q == ST_PAYLOAD) &&
                           (type_q == C_TYPE_MWR) && (cnt_q != 9'd0) &&
                           (!tvalid_q || tx_axis_tready);

  assign beat_xfer = tvalid_q && tx_axis_tready;
  assign mwr_take  = tx_mwr_data_valid && tx_mwr_data_rdy;

  assign known_type = (tx_arb_type == C_TYPE_CPLD) || (tx_arb_type == C_TYPE_MRD) ||
                      (tx_arb_type == C_TYPE_MWR);
  assign is_cpld    = (tx_arb_type == C_TYPE_CPLD);
  assign len_bad    = (tx_pcie_len == 11'd0) || (tx_pcie_len > C_MAX_DW_LEN) ||
                      (is_cpld && (tx_pcie_len > 11'd2));
  // Oversized lengths are clamped so the 9-bit beat counter cannot wrap.
  assign eff_len    = (tx_pcie_len > C_MAX_DW_LEN) ? C_MAX_DW_LEN : tx_pcie_len;

  always_comb begin
    // NOTE: every *_d gets a hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    type_d     = type_q;
    len_d      = len_q;
    udata_d    = udata_q;
    cnt_d      = cnt_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tdest_d    = tdest_q;
    done_d     = 1'b0;
    done_gnt_d = 6'd0;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        // Unknown types are accepted and silently dropped (stay in IDLE).
        if (tx_arb_valid && tx_arb_rdy && known_type) begin
          gnt_d    = tx_arb_gnt;
          type_d   = tx_arb_type;
          len_d    = eff_len;
          udata_d  = tx_cpld_udata;
          err_d    = err_q || len_bad;
          tvalid_d = 1'b1;
          tdata_d  = tx_pcie_head;
          tkeep_d  = 4'b1111;
          tdest_d  = is_cpld ? C_TDEST_CPL : C_TDEST_REQ;
          // Header-only TLPs: MRd, 1-DW CplD, and any zero-length request.
          tlast_d  = (tx_arb_type == C_TYPE_MRD) || (tx_pcie_len == 11'd0) ||
                     (is_cpld && (tx_pcie_len == 11'd1));
          state_d  = ST_HEAD;
        end
      end

      ST_HEAD: begin
        if (beat_xfer) begin
          if (tlast_q) begin
            tvalid_d   = 1'b0;
            done_d     = 1'b1;
            done_gnt_d = gnt_q;
            state_d    = ST_IDLE;
          end else if (type_q == C_TYPE_CPLD) begin
            // CplD len >= 2 always sends exactly one extra DW.
            tdata_d = {{(C_PCIE_DATA_WIDTH-32){1'b0}}, udata_q};
            tkeep_d = 4'b0001;
            tlast_d = 1'b1;
            state_d = ST_PAYLOAD;
          end else begin
            tvalid_d = 1'b0;
            cnt_d    = mwr_beats(len_q);
            state_d  = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (beat_xfer) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            done_d     = 1'b1;
            done_gnt_d = gnt_q;
            state_d    = ST_IDLE;
          end
        end
        // A new payload beat may replace the one leaving in the same cycle.
        if (mwr_take) begin
          tvalid_d = 1'b1;
          tdata_d  = tx_mwr_data;
          tlast_d  = (cnt_q == 9'd1);
          tkeep_d  = (cnt_q == 9'd1) ? last_keep(len_q[1:0]) : 4'b1111;
          cnt_d    = cnt_q - 9'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pcie_user_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (pcie_user_rst) begin
      // NOTE: the datapath registers are reset too, because tdata/tkeep must
      // read as zero during reset, not just tvalid.
      state_q    <= ST_IDLE;
      gnt_q      <= 6'd0;
      type_q     <= 3'd0;
      len_q      <= 11'd0;
      udata_q    <= 32'd0;
      cnt_q      <= 9'd0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= 4'd0;
      tlast_q    <= 1'b0;
      tdest_q    <= 1'b0;
      done_q     <= 1'b0;
      done_gnt_q <= 6'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      type_q     <= type_d;
      len_q      <= len_d;
      udata_q    <= udata_d;
      cnt_q      <= cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tdest_q    <= tdest_d;
      done_q     <= done_d;
      done_gnt_q <= done_gnt_d;
      err_q      <= err_d;
    end
  end

  assign tx_axis_tvalid = tvalid_q;
  assign tx_axis_tdata  = tdata_q;
  assign tx_axis_tkeep  = tkeep_q;
  assign tx_axis_tlast  = tlast_q;
  assign tx_axis_tdest  = tdest_q;
  assign tx_done        = done_q;
  assign tx_done_gnt    = done_gnt_q;
  assign tx_err_len     = err_q;

endmodule

// File: tb/tb_pcie_tx_tlp_gen.sv
// -----------------------------------------------------------------------------
// tb_pcie_tx_tlp_gen
// Directed bench for pcie_tx_tlp_gen. A negedge monitor records every stream
// transfer and done pulse and checks that a stalled beat holds; directed tests
// compare the recorded beats with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pcie_tx_tlp_gen;

  logic         clk;
  logic         rst;
  logic         arb_valid;
  logic [5:0]   arb_gnt;
  logic [2:0]   arb_type;
  logic [10:0]  pcie_len;
  logic [127:0] pcie_head;
  logic [31:0]  cpld_udata;
  logic         arb_rdy;
  logic [127:0] mwr_data;
  logic         mwr_valid;
  logic         mwr_rdy;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic         tlast;
  logic         tdest;
  logic         tvalid;
  logic         tready;
  logic         done;
  logic [5:0]   done_gnt;
  logic         err_len;

  pcie_tx_tlp_gen #(.C_PCIE_DATA_WIDTH(128)) dut (
    .pcie_user_clk    (clk),
    .pcie_user_rst    (rst),
    .tx_arb_valid     (arb_valid),
    .tx_arb_gnt       (arb_gnt),
    .tx_arb_type      (arb_type),
    .tx_pcie_len      (pcie_len),
    .tx_pcie_head     (pcie_head),
    .tx_cpld_udata    (cpld_udata),
    .tx_arb_rdy       (arb_rdy),
    .tx_mwr_data      (mwr_data),
    .tx_mwr_data_valid(mwr_valid),
    .tx_mwr_data_rdy  (mwr_rdy),
    .tx_axis_tdata    (tdata),
    .tx_axis_tkeep    (tkeep),
    .tx_axis_tlast    (tlast),
    .tx_axis_tdest    (tdest),
    .tx_axis_tvalid   (tvalid),
    .tx_axis_tready   (tready),
    .tx_done          (done),
    .tx_done_gnt      (done_gnt),
    .tx_err_len       (err_len)
  );

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic         dest;
  } beat_t;

  beat_t      beats[$];
  logic [5:0] dones[$];

  int n_pass  = 0;
  int n_total = 0;

  bit tready_toggle = 1'b0;
  bit feed_abort    = 1'b0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] pat(input int k);
    return {32'(k), 32'hA5A5_0000 ^ 32'(k), ~32'(k), 32'h1234_0000 + 32'(k)};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = tready_toggle ? ~tready : 1'b1;
    end
  end

  // Monitor: record transfers/done pulses, check hold while stalled.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_keep;
  logic         prev_last;
  logic         prev_dest;

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", tdata, prev_data);
        check("stall_ctl", {tvalid, tkeep, tlast, tdest}, {1'b1, prev_keep, prev_last, prev_dest});
      end
      if (tvalid && tready) begin
        b.data = tdata;
        b.keep = tkeep;
        b.last = tlast;
        b.dest = tdest;
        beats.push_back(b);
      end
      if (done) dones.push_back(done_gnt);
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_keep  = tkeep;
      prev_last  = tlast;
      prev_dest  = tdest;
    end
  end

  task automatic clear_logs();
    beats.delete();
    dones.delete();
  endtask

  task automatic send_req(input logic [5:0] gnt, input logic [2:0] typ, input logic [10:0] len,
                          input logic [127:0] head, input logic [31:0] udata);
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    arb_valid  = 1'b1;
    arb_gnt    = gnt;
    arb_type   = typ;
    pcie_len   = len;
    pcie_head  = head;
    cpld_udata = udata;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (arb_rdy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("arb_rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    arb_valid = 1'b0;
  endtask

  task automatic feed_payload(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    bit took;
    mwr_valid = 1'b1;
    mwr_data  = pat(0);
    while (i < n && !feed_abort && guard < 20000) begin
      @(negedge clk);
      took = mwr_valid && mwr_rdy;
      @(posedge clk);
      #1;
      guard++;
      if (took) i++;
      if (i < n && (took || !mwr_valid)) begin
        if (gaps && $urandom_range(0, 2) == 0) mwr_valid = 1'b0;
        else begin
          mwr_valid = 1'b1;
          mwr_data  = pat(i);
        end
      end
    end
    mwr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit chk_rdy);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        if (chk_rdy) check("b2b_rdy_with_done", arb_rdy, 1'b1);
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [127:0] data,
                            input logic [3:0] keep, input logic last, input logic dest);
    if (idx < beats.size()) begin
      check({tag, "_data"}, beats[idx].data, data);
      check({tag, "_ctl"}, {beats[idx].keep, beats[idx].last, beats[idx].dest}, {keep, last, dest});
    end else begin
      check({tag, "_missing"}, beats.size(), idx + 1);
    end
  endtask

  task automatic check_done(input string tag, input logic [5:0] gnt);
    check({tag, "_ndone"}, dones.size(), 1);
    if (dones.size() > 0) check({tag, "_gnt"}, dones[0], gnt);
  endtask

  localparam logic [127:0] H_MRD  = 128'h0000_0010_0000_00FF_1111_2222_3333_4444;
  localparam logic [127:0] H_CPL  = 128'h4A00_0002_ABCD_0008_0102_0304_0506_0708;
  localparam logic [127:0] H_MWR  = 128'h6000_0006_0000_00FF_DEAD_0000_BEEF_0000;
  localparam logic [127:0] H_MISC = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;

  initial begin
    int bad;
    bit found;

    rst        = 1'b1;
    arb_valid  = 1'b0;
    arb_gnt    = 6'd0;
    arb_type   = 3'd0;
    pcie_len   = 11'd0;
    pcie_head  = '0;
    cpld_udata = 32'd0;
    mwr_valid  = 1'b0;
    mwr_data   = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_arb_rdy", arb_rdy, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tkeep", tkeep, 4'd0);
    check("rst_tdata", tdata, 128'd0);
    check("rst_tdest", tdest, 1'b0);
    check("rst_mwr_rdy", mwr_rdy, 1'b0);
    check("rst_done", {done, done_gnt}, 7'd0);
    check("rst_err", err_len, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rdy_after_rst", arb_rdy, 1'b1);

    // MRd len=16
    clear_logs();
    send_req(6'b000010, 3'b010, 11'd16, H_MRD, 32'd0);
    @(negedge clk);
    #1;
    check("mrd_hdr_latency", tvalid, 1'b1);
    check("mrd_rdy_low", arb_rdy, 1'b0);
    wait_done(20, 1'b1);
    check("mrd_nbeats", beats.size(), 1);
    check_beat("mrd_b0", 0, H_MRD, 4'b1111, 1'b1, 1'b0);
    check_done("mrd", 6'b000010);

    // CplD len=2
    clear_logs();
    send_req(6'b000001, 3'b001, 11'd2, H_CPL, 32'hDEADBEEF);
    wait_done(20, 1'b0);
    check("cpl2_nbeats", beats.size(), 2);
    check_beat("cpl2_b0", 0, H_CPL, 4'b1111, 1'b0, 1'b1);
    check_beat("cpl2_b1", 1, {96'd0, 32'hDEADBEEF}, 4'b0001, 1'b1, 1'b1);
    check_done("cpl2", 6'b000001);

    // CplD len=1
    clear_logs();
    send_req(6'b000001, 3'b001, 11'd1, H_MISC, 32'h0BAD_F00D);
    wait_done(20, 1'b0);
    check("cpl1_nbeats", beats.size(), 1);
    check_beat("cpl1_b0", 0, H_MISC, 4'b1111, 1'b1, 1'b1);

    // MWr0 len=6, continuous payload
    clear_logs();
    send_req(6'b010000, 3'b100, 11'd6, H_MWR, 32'd0);
    fork
      feed_payload(2, 1'b0);
      wait_done(50, 1'b1);
    join
    check("mwr6_nbeats", beats.size(), 3);
    check_beat("mwr6_b0", 0, H_MWR, 4'b1111, 1'b0, 1'b0);
    check_beat("mwr6_b1", 1, pat(0), 4'b1111, 1'b0, 1'b0);
    check_beat("mwr6_b2", 2, pat(1), 4'b0011, 1'b1, 1'b0);
    check_done("mwr6", 6'b010000);

    // Last-beat keep for len%4 == 1 and 3
    clear_logs();
    send_req(6'b100000, 3'b100, 11'd5, H_MWR, 32'd0);
    fork
      feed_payload(2, 1'b0);
      wait_done(50, 1'b0);
    join
    check("mwr5_nbeats", beats.size(), 3);
    check_beat("mwr5_b2", 2, pat(1), 4'b0001, 1'b1, 1'b0);
    clear_logs();
    send_req(6'b100000, 3'b100, 11'd7, H_MWR, 32'd0);
    fork
      feed_payload(2, 1'b0);
      wait_done(50, 1'b0);
    join
    check_beat("mwr7_b2", 2, pat(1), 4'b0111, 1'b1, 1'b0);

    // Unknown type: accepted and dropped
    clear_logs();
    send_req(6'b000100, 3'b011, 11'd4, H_MISC, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("drop_nbeats", beats.size(), 0);
    check("drop_ndone", dones.size(), 0);
    check("drop_state", {tvalid, arb_rdy}, 2'b01);

    // MWr1 len=1024, tready toggling, payload gaps
    clear_logs();
    tready_toggle = 1'b1;
    send_req(6'b100000, 3'b100, 11'd1024, H_MWR, 32'd0);
    fork
      feed_payload(256, 1'b1);
      wait_done(5000, 1'b0);
    join
    tready_toggle = 1'b0;
    check("mwr1k_nbeats", beats.size(), 257);
    check_beat("mwr1k_hdr", 0, H_MWR, 4'b1111, 1'b0, 1'b0);
    bad = 0;
    for (int i = 1; i < beats.size() && i <= 256; i++) begin
      if (beats[i].data !== pat(i - 1) || beats[i].last !== (i == 256)) bad++;
    end
    check("mwr1k_order", bad, 0);
    if (beats.size() == 257) check("mwr1k_last_keep", beats[256].keep, 4'b1111);
    check_done("mwr1k", 6'b100000);
    check("err_still_clear", err_len, 1'b0);
    repeat (2) @(posedge clk);

    // Reset during 3rd payload beat of MWr len=64
    clear_logs();
    send_req(6'b010000, 3'b100, 11'd64, H_MWR, 32'd0);
    feed_abort = 1'b0;
    fork
      feed_payload(16, 1'b0);
    join_none
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (beats.size() == 3 && tvalid) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_p2", found, 1'b1);
    rst        = 1'b1;
    feed_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("abort_tvalid", tvalid, 1'b0);
    check("abort_mwr_rdy", mwr_rdy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_rdy_after", arb_rdy, 1'b1);
    check("abort_ndone", dones.size(), 0);
    check("abort_nbeats", beats.size(), 3);
    repeat (3) @(posedge clk);
    clear_logs();
    send_req(6'b000100, 3'b010, 11'd4, H_MRD, 32'd0);
    wait_done(20, 1'b0);
    check("post_abort_nbeats", beats.size(), 1);
    check_beat("post_abort_b0", 0, H_MRD, 4'b1111, 1'b1, 1'b0);
    check_done("post_abort", 6'b000100);

    // Illegal lengths
    check("err_before", err_len, 1'b0);
    clear_logs();
    send_req(6'b000001, 3'b001, 11'd3, H_CPL, 32'h1357_9BDF);
    wait_done(20, 1'b0);
    check("err_cpl3_flag", err_len, 1'b1);
    check("err_cpl3_nbeats", beats.size(), 2);
    check_beat("err_cpl3_b1", 1, {96'd0, 32'h1357_9BDF}, 4'b0001, 1'b1, 1'b1);
    clear_logs();
    send_req(6'b010000, 3'b100, 11'd0, H_MWR, 32'd0);
    wait_done(20, 1'b0);
    check("err_mwr0_nbeats", beats.size(), 1);
    check_beat("err_mwr0_b0", 0, H_MWR, 4'b1111, 1'b1, 1'b0);
    check_done("err_mwr0", 6'b010000);
    repeat (3) @(negedge clk);
    check("err_sticky", err_len, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcie_tx_tlp_gen.md
PCIE_TX_TLP_GEN -- requirements
Module: pcie_tx_tlp_gen

Interface
REQ-001 SHALL have parameter C_PCIE_DATA_WIDTH, default 128: output stream width in bits; only 128 is supported.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 pcie_user_clk  in  1  sole clock.
REQ-004 pcie_user_rst  in  1  synchronous active-high reset.
REQ-005 tx_arb_valid  in  1  arbiter offers a request.
REQ-006 tx_arb_gnt  in  6  one-hot source: [0] CplD, [1..3] MRd0..2, [4..5] MWr0..1.
REQ-007 tx_arb_type  in  3  001 CplD, 010 MRd, 100 MWr.
REQ-008 tx_pcie_len  in  11  payload length in DW, bits [12:2], legal 1..1024.
REQ-009 tx_pcie_head  in  128  complete header beat.
REQ-010 tx_cpld_udata  in  32  second CplD data DW.
REQ-011 tx_arb_rdy  out  1  accept strobe to the arbiter.
REQ-012 tx_mwr_data, tx_mwr_data_valid, tx_mwr_data_rdy  in/in/out  128/1/1  MWr payload stream.
REQ-013 tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tdest, tx_axis_tvalid  out  128/4/1/1/1  TLP stream.
- tkeep is per DW.
- tdest: 0 = requester path, 1 = completer path.
REQ-014 tx_axis_tready  in  1  downstream ready.
REQ-015 tx_done, tx_done_gnt  out  1/6  one-cycle pulse plus the grant of the finished TLP.
REQ-016 tx_err_len  out  1  sticky illegal-length flag.

Function
REQ-017 SHALL implement an FSM with states IDLE, HEAD and PAYLOAD.
REQ-018 tx_arb_rdy SHALL be 1 only in IDLE.
REQ-019 On tx_arb_valid & tx_arb_rdy, the block SHALL capture gnt, type, len, head and udata, then enter HEAD.
REQ-020 Entering HEAD SHALL drive tvalid=1 on the next cycle, carrying the captured head with tkeep=1111.
REQ-021 Output stream handshake:
- A beat transfers when tvalid & tready.
- tdata, tkeep, tlast and tdest SHALL hold stable while tvalid & !tready.
REQ-022 MRd SHALL be one beat with tlast=1 and tdest=0; on transfer, return to IDLE.
REQ-023 CplD SHALL use tdest=1.
- len=1: one beat, tlast=1.
- len=2: header beat tlast=0, then PAYLOAD beat {96'b0, udata}, tkeep=0001, tlast=1.
REQ-024 MWr SHALL send the header beat (tlast=0, tdest=0), then (len+3)>>2 payload beats from tx_mwr_data.
- Beat count uses a 9-bit counter.
REQ-025 tx_mwr_data_rdy SHALL be 1 only in PAYLOAD for MWr while the output register is empty or being emptied.
- A stalled payload stream SHALL produce tvalid=0 with no timeout.
REQ-026 Last MWr beat SHALL set tlast=1, with tkeep selected by len[3:2]:
- 00 -> 1111
- 01 -> 0001
- 10 -> 0011
- 11 -> 0111
REQ-027 Illegal lengths (len=0, or CplD len>2) SHALL set tx_err_len.
- len=0: header beat only, with tlast=1.
- CplD len>2: handled as len=2.
REQ-028 On the tlast transfer, the block SHALL pulse tx_done for 1 cycle with the captured gnt, and enter IDLE.
- tx_arb_rdy returns on the next cycle, so the back-to-back gap is 1 idle cycle.
REQ-029 Latency SHALL be accept at cycle N -> header tvalid at N+1, assuming tready=1.
REQ-030 tx_arb_valid with type not in {001, 010, 100} SHALL be accepted and dropped, with no beat and no tx_done.

Reset
REQ-031 While pcie_user_rst=1, outputs SHALL be:
- tx_arb_rdy=0
- tvalid=0, tlast=0, tkeep=0, tdata=0, tdest=0
- tx_mwr_data_rdy=0
- tx_done=0, tx_done_gnt=0
- tx_err_len=0
- state=IDLE
REQ-032 tx_arb_rdy SHALL be 1 on the first cycle after reset is released.
REQ-033 Reset asserted mid-TLP SHALL abort it immediately.
- No tlast and no tx_done are produced.
- Unconsumed payload stays upstream.

Structure
REQ-034 The following constants SHALL reside in shared def_pcie.vh:
- type codes (001/010/100)
- tdest codes
- max DW length 1024
- state encodings
REQ-035 SHALL be a single module with no sub-module; the output register lives in-module.

Verification
REQ-036 MRd, len=16, tready=1 -> rdy low 1 cycle after accept; 1 beat, tkeep=1111, tlast=1, tdest=0; tx_done with gnt=000010.
REQ-037 CplD, len=2, udata=0xDEADBEEF -> 2 beats, beat2 tdata[31:0]=0xDEADBEEF, tkeep=0001, tdest=1; tx_done with gnt=000001.
REQ-038 MWr0, len=6, payload valid continuously -> header + 2 beats, last tkeep=0011; tx_done with gnt=010000.
REQ-039 MWr1, len=1024, tready toggling 1/0 and payload valid gaps -> exactly 257 transfers, data order preserved, no beat changes while stalled.
REQ-040 Reset asserted on 3rd payload beat of MWr len=64 -> tvalid=0 next cycle, no tx_done, rdy=1 after release; next MRd correct.
REQ-041 CplD len=3 and MWr len=0 -> tx_err_len=1 sticky; CplD sends 2 beats; MWr sends 1 beat with tlast=1.
